// File: rtl/wfg_spi_wbm_bridge.sv
// rtl/wfg_spi_wbm_bridge.sv - SPI-slave (mode 0) to Wishbone-master bridge
// Host frames cmd/addr/data over SPI; the bridge issues one Wishbone cycle per frame.
module wfg_spi_wbm_bridge #(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            spi_sclk_i,
  input  logic            spi_cs_ni,
  input  logic            spi_sdi_i,
  output logic            spi_sdo_o,
  output logic            spi_sdo_en_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [3:0]      wbm_sel_o,
  output logic [BUSW-1:0] wbm_adr_o,
  output logic [BUSW-1:0] wbm_dat_o,
  input  logic [BUSW-1:0] wbm_dat_i,
  input  logic            wbm_ack_i,
  output logic            busy_o,
  output logic            timeout_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WR_DATA, S_RD_DUMMY, S_RD_DATA, S_WAIT_CS
  } state_t;

  localparam int            TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);
  localparam logic [5:0]    LAST_DATA = 6'(BUSW - 1);
  localparam logic [BUSW-1:0] RD_PRELOAD = BUSW'(32'hDEAD_BEEF);

  logic [2:0]      r_sclk_s;
  logic [1:0]      r_cs_s;
  logic [1:0]      r_sdi_s;
  state_t          r_state;
  logic [5:0]      r_cnt;
  logic [BUSW-1:0] r_sh;
  logic [7:0]      r_addr;
  logic [BUSW-1:0] r_rd_shift;
  logic            r_rd_started;
  logic            r_sdo;
  logic            r_cyc;
  logic            r_we;
  logic [BUSW-1:0] r_adr;
  logic [BUSW-1:0] r_dat;
  logic [TW-1:0]   r_tmr;
  logic            r_timeout;
  logic            r_pend;
  logic            r_pend_we;
  logic [BUSW-1:0] r_pend_adr;
  logic [BUSW-1:0] r_pend_dat;

  logic            w_rise, w_fall, w_cs_n, w_sdi;
  logic            w_hdr_done, w_wr_done, w_issue;
  logic [BUSW-1:0] w_issue_adr, w_issue_dat;

  assign w_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_cs_n = r_cs_s[1];
  assign w_sdi  = r_sdi_s[1];

  assign w_hdr_done  = (r_state == S_HDR) && w_rise && !w_cs_n && (r_cnt == 6'd15);
  assign w_wr_done   = (r_state == S_WR_DATA) && w_rise && !w_cs_n && (r_cnt == LAST_DATA);
  assign w_issue     = (w_hdr_done && !r_sh[14]) || w_wr_done;
  assign w_issue_adr = w_hdr_done ? {{(BUSW-8){1'b0}}, r_sh[6:0], w_sdi}
                                  : {{(BUSW-8){1'b0}}, r_addr};
  assign w_issue_dat = w_wr_done ? {r_sh[BUSW-2:0], w_sdi} : '0;

  // CS sync resets to deasserted so a reset never looks like a frame start
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sclk_s <= '0;
      r_cs_s   <= 2'b11;
      r_sdi_s  <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], spi_sclk_i};
      r_cs_s   <= {r_cs_s[0], spi_cs_ni};
      r_sdi_s  <= {r_sdi_s[0], spi_sdi_i};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_addr       <= '0;
      r_rd_shift   <= '0;
      r_rd_started <= 1'b0;
      r_sdo        <= 1'b0;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_tmr        <= '0;
      r_timeout    <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_adr   <= '0;
      r_pend_dat   <= '0;
    end else begin
      r_timeout <= 1'b0;
      if (r_cyc) begin
        if (wbm_ack_i) begin
          r_cyc <= 1'b0;
          if (!r_we && !r_rd_started) r_rd_shift <= wbm_dat_i;
        end else if (r_tmr == TMR_LAST) begin
          r_cyc     <= 1'b0;
          r_timeout <= 1'b1;
        end else begin
          r_tmr <= r_tmr + TW'(1);
        end
      end else if (r_pend) begin
        r_cyc  <= 1'b1;
        r_we   <= r_pend_we;
        r_adr  <= r_pend_adr;
        r_dat  <= r_pend_dat;
        r_tmr  <= '0;
        r_pend <= 1'b0;
      end

      // A cycle still in flight from the previous frame defers this one
      if (w_issue) begin
        if (!r_cyc && !r_pend) begin
          r_cyc <= 1'b1;
          r_we  <= w_wr_done;
          r_adr <= w_issue_adr;
          r_dat <= w_issue_dat;
          r_tmr <= '0;
        end else begin
          r_pend     <= 1'b1;
          r_pend_we  <= w_wr_done;
          r_pend_adr <= w_issue_adr;
          r_pend_dat <= w_issue_dat;
        end
        if (!w_wr_done) begin
          r_rd_shift   <= RD_PRELOAD;
          r_rd_started <= 1'b0;
        end
      end

      if (r_state != S_IDLE && w_cs_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (!w_cs_n) begin
            r_state <= S_HDR;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_sdo   <= 1'b0;
          end
          S_HDR: if (w_rise) begin
            r_sh <= {r_sh[BUSW-2:0], w_sdi};
            if (r_cnt == 6'd15) begin
              r_cnt   <= '0;
              r_addr  <= {r_sh[6:0], w_sdi};
              r_state <= r_sh[14] ? S_WR_DATA : S_RD_DUMMY;
            end else r_cnt <= r_cnt + 6'd1;
          end
          S_WR_DATA: if (w_rise) begin
            r_sh <= {r_sh[BUSW-2:0], w_sdi};
            if (r_cnt == LAST_DATA) begin
              r_cnt   <= '0;
              r_state <= S_WAIT_CS;
            end else r_cnt <= r_cnt + 6'd1;
          end
          S_RD_DUMMY: if (w_rise) begin
            if (r_cnt == 6'd7) begin
              r_cnt   <= '0;
              r_state <= S_RD_DATA;
            end else r_cnt <= r_cnt + 6'd1;
          end
          S_RD_DATA: begin
            // First falling edge presents bit 31; each later one shifts
            if (w_fall) begin
              r_sdo        <= r_rd_started ? r_rd_shift[BUSW-2] : r_rd_shift[BUSW-1];
              r_rd_started <= 1'b1;
              if (r_rd_started) r_rd_shift <= r_rd_shift << 1;
            end
            if (w_rise) begin
              if (r_cnt == LAST_DATA) begin
                r_cnt   <= '0;
                r_state <= S_WAIT_CS;
              end else r_cnt <= r_cnt + 6'd1;
            end
          end
          S_WAIT_CS: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign spi_sdo_en_o = ((r_state == S_RD_DUMMY) || (r_state == S_RD_DATA)) && !w_cs_n;
  assign spi_sdo_o    = spi_sdo_en_o & r_sdo;
  assign wbm_cyc_o    = r_cyc;
  assign wbm_stb_o    = r_cyc;
  assign wbm_we_o     = r_cyc & r_we;
  assign wbm_sel_o    = r_cyc ? 4'hF : 4'h0;
  assign wbm_adr_o    = r_adr;
  assign wbm_dat_o    = r_dat;
  assign busy_o       = (r_state != S_IDLE) || r_cyc || r_pend;
  assign timeout_o    = r_timeout;
endmodule
